uart_tx_bps: RTL and testbench
==============================

// Module: uart_tx_bps
// PURPOSE
//  Serial transmitter driven by the single-cycle bit-rate tick (bps tick) from the
//  team's baud/period counter. Accepts one parallel word via valid/ready, emits an
//  asynchronous serial frame: start, DATA_W bits LSB first, optional parity, stop bit(s).
//  Sits between the command/display logic and the board TX pin. No internal divider:
//  bit timing comes only from bps_tick.
// PARAMETERS
//  DATA_W     8  payload bits per frame (5..9)
//  PARITY_EN  0  1 = append parity bit after data
//  PARITY_ODD 0  1 = odd parity, 0 = even parity (only if PARITY_EN=1)
//  STOP_BITS  1  number of stop-bit periods (1 or 2)
// PORTS
//  clk       in   1       system clock
//  rst_n     in   1       asynchronous active-low reset
//  bps_tick  in   1       1-cycle pulse, one per bit period
//  tx_data   in   DATA_W  word to send; sampled on accept
//  tx_valid  in   1       word available
//  tx_ready  out  1       block can accept (high only in IDLE)
//  tx        out  1       serial line, idle high, registered
//  busy      out  1       frame in progress (= ~tx_ready)
//  done      out  1       1-cycle pulse when last stop period ends
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, tx=1, done=0, shift reg/counters=0; tx_ready=1 on release.
//  Accept: tx_valid & tx_ready at a clk edge latches tx_data into shift reg, computes parity
//   (even: ^data, odd: ~^data), state -> ARM. tx_data/tx_valid ignored when not IDLE.
//  States, all advances only on clk edges where bps_tick=1:
//   IDLE : tx=1. Leaves only on accept (bps_tick irrelevant).
//   ARM  : tx=1, waits for next bps_tick; then tx<=0 -> START. A tick in the accept
//          cycle itself is NOT used; ARM always waits for a later tick.
//   START: on tick tx<=d[0], bit_idx<=0 -> DATA.
//   DATA : on tick, if bit_idx==DATA_W-1: tx<=parity -> PARITY (PARITY_EN) else
//          tx<=1 -> STOP; otherwise bit_idx++, tx<=d[bit_idx+1].
//   PARITY: on tick tx<=1, stop_cnt<=0 -> STOP.
//   STOP : on tick, if stop_cnt==STOP_BITS-1: -> IDLE, done=1 for that one cycle, tx stays 1;
//          else stop_cnt++.
//  Timing: every bit is held exactly one tick interval; tx changes only on tick edges
//   (except reset). Frame = 1+DATA_W+PARITY_EN+STOP_BITS tick intervals after the ARM tick.
//  tx_ready=1 only in IDLE (combinational from state); asserts the cycle after done, so
//   back-to-back frames: held tx_valid is accepted next cycle, start bit at following tick;
//   stop bit therefore never shortened.
//  bps_tick high every cycle: legal, one bit per clk cycle.
//  Reset mid-frame: tx forced to 1 immediately, frame aborted, no done pulse.
//  bit_idx width clog2(DATA_W); stop_cnt 1 bit; no counter wraps outside listed transitions.
// TESTING
//  T1 8N1, tick every 4 clk, send 0x55 -> tx per tick: 0,1,0,1,0,1,0,1,0,1; done once, tx_ready re-asserts next cycle.
//  T2 PARITY_EN=1 even, send 0x07 -> parity bit 1; PARITY_ODD=1 send 0x07 -> parity bit 0; frame 11 ticks.
//  T3 STOP_BITS=2, tick every clk, send 0xA3 -> tx 0,1,1,0,0,0,1,0,1,1,1; done in 11th tick cycle.
//  T4 tx_valid held high, words 0x12 then 0x34 -> two contiguous frames, stop bit of first lasts full tick period, no word lost or repeated.
//  T5 bps_tick asserted in accept cycle -> tx stays 1 until next tick; tx_valid pulse while busy -> ignored, frame data unchanged.
//  T6 rst_n low during DATA bit 3 -> tx=1 asynchronously, no done, tx_ready=1 after release; next frame 0xF0 correct.

Source files
------------

// File: rtl/uart_tx_bps.sv
// Tick-paced UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// STOP_BITS stop periods. All bit timing comes from bps_tick; there is no internal divider.
module uart_tx_bps #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bps_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // Handshake: a word transfers on a clk edge where tx_valid and tx_ready are both high.
  // tx_ready is high only in IDLE; tx_data/tx_valid are ignored in every other state.

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic PAR_EN    = (PARITY_EN != 0);
  localparam logic PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          shift_d  = tx_data;
          parity_d = PAR_ODD ? ~^tx_data : ^tx_data;
          state_d  = S_ARM;
        end
      end
      // A tick coinciding with the accept edge was seen in IDLE, so ARM always
      // waits for a later tick before driving the start bit.
      S_ARM: begin
        if (bps_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bps_tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bps_tick) begin
          if (bit_idx_q == LAST_IDX) begin
            stop_cnt_d = 1'b0;
            if (PAR_EN) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bps_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (bps_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // done is combinational so tx_ready rises the cycle after the done pulse.
  assign done      = done_d;
  assign tx        = tx_q;
  assign tx_ready  = (state_q == S_IDLE);
  assign busy      = ~tx_ready;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_bps.sv
// Bench for uart_tx_bps: five configurations share stimulus, each checked every cycle
// against a frame-list model, plus literal frame captures for the directed cases.
module tb_uart_tx_bps;

  localparam int N = 5;
  localparam int DW_A [N] = '{8, 8, 8, 8, 5};
  localparam int PEN  [N] = '{0, 1, 1, 0, 1};
  localparam int PODD [N] = '{0, 0, 1, 0, 1};
  localparam int STB  [N] = '{1, 1, 1, 2, 2};

  logic clk = 1'b0;
  logic rst_n;
  logic bps_tick = 1'b0;
  logic tx_valid;
  logic [7:0] tx_data;
  logic [N-1:0] tx_w, ready_w, busy_w, done_w;
  logic [N-1:0][2:0] st_w;

  uart_tx_bps #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .dbg_state(st_w[0]));
  uart_tx_bps #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .dbg_state(st_w[1]));
  uart_tx_bps #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]), .dbg_state(st_w[2]));
  uart_tx_bps #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]), .dbg_state(st_w[3]));
  uart_tx_bps #(.DATA_W(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u4 (
    .clk(clk), .rst_n(rst_n), .bps_tick(bps_tick), .tx_data(tx_data[4:0]), .tx_valid(tx_valid),
    .tx_ready(ready_w[4]), .tx(tx_w[4]), .busy(busy_w[4]), .done(done_w[4]), .dbg_state(st_w[4]));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- tick generator ----------------
  int   tick_mode = 1;   // 0 none, 1 periodic, 2 every clk, 3 random
  int   tick_per  = 4;
  int   tick_cnt  = 0;
  logic tick_force = 1'b0;

  always begin
    logic gen;
    @(posedge clk);
    #2;
    gen = 1'b0;
    case (tick_mode)
      1: begin
        if (tick_cnt >= tick_per - 1) begin
          gen = 1'b1;
          tick_cnt = 0;
        end else begin
          tick_cnt++;
        end
      end
      2: gen = 1'b1;
      3: gen = ($urandom_range(0, 2) == 0);
      default: gen = 1'b0;
    endcase
    bps_tick = gen | tick_force;
  end

  // ---------------- model and scoreboard ----------------
  // Each accepted word becomes a list of line levels; every tick after the accept
  // edge puts the next level on the line, and one tick past the end raises done.
  logic [31:0] m_fr [N];
  int          m_len [N];
  int          m_pos [N];
  bit          m_busy [N];
  logic        m_tx [N];
  bit          popped [N];
  logic [31:0] cap [N];
  int          cap_n [N];
  int          acc_cnt [N];
  int          done_cnt [N];
  logic [2:0]  idle_code [N];
  int          n_checks = 0;
  int          n_fail = 0;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_fr[i] = '0; m_len[i] = 0; m_pos[i] = 0; m_busy[i] = 1'b0; m_tx[i] = 1'b1;
      popped[i] = 1'b0; cap[i] = '0; cap_n[i] = 0; acc_cnt[i] = 0; done_cnt[i] = 0;
      idle_code[i] = '0;
    end
  end

  task automatic check1(string name, int inst, logic got, logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %b expected %b at %0t", name, inst, got, exp, $time);
    end
  endtask

  task automatic check_vec(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic e_tx, e_rdy, e_done;
    logic [7:0] dm;
    int n;
    for (int i = 0; i < N; i++) begin
      if (popped[i]) begin
        if (cap_n[i] < 32) cap[i][cap_n[i]] = tx_w[i];
        cap_n[i]++;
        popped[i] = 1'b0;
      end
      if (done_w[i]) done_cnt[i]++;
      if (!rst_n) begin
        e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
      end else begin
        e_tx   = m_tx[i];
        e_rdy  = !m_busy[i];
        e_done = m_busy[i] && bps_tick && (m_pos[i] == m_len[i]);
      end
      check1("tx", i, tx_w[i], e_tx);
      check1("tx_ready", i, ready_w[i], e_rdy);
      check1("busy", i, busy_w[i], !e_rdy);
      check1("done", i, done_w[i], e_done);
      check1("dbg_idle", i, (st_w[i] == idle_code[i]), e_rdy);
      // advance the model across the coming clk edge
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_tx[i] = 1'b1; m_pos[i] = 0;
      end else if (m_busy[i] && bps_tick) begin
        if (m_pos[i] == m_len[i]) begin
          m_busy[i] = 1'b0;
        end else begin
          m_tx[i] = m_fr[i][m_pos[i]];
          m_pos[i]++;
          popped[i] = 1'b1;
        end
      end else if (!m_busy[i] && tx_valid) begin
        dm = tx_data & 8'((1 << DW_A[i]) - 1);
        m_fr[i] = '0;
        m_fr[i][0] = 1'b0;
        for (int k = 0; k < DW_A[i]; k++) m_fr[i][1 + k] = dm[k];
        n = 1 + DW_A[i];
        if (PEN[i] != 0) begin
          m_fr[i][n] = (^dm) ^ (PODD[i] != 0);
          n++;
        end
        for (int s = 0; s < STB[i]; s++) begin
          m_fr[i][n] = 1'b1;
          n++;
        end
        m_len[i]  = n;
        m_pos[i]  = 0;
        m_busy[i] = 1'b1;
        acc_cnt[i]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_busy();
    bit b = 1'b0;
    for (int i = 0; i < N; i++) b |= m_busy[i];
    return b;
  endfunction

  task automatic wait_all_idle(int budget);
    int c = 0;
    while (any_busy() && c < budget) begin
      cyc();
      c++;
    end
    if (any_busy()) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
    cyc();
  endtask

  task automatic clr_cap();
    for (int i = 0; i < N; i++) begin
      cap[i] = '0; cap_n[i] = 0; acc_cnt[i] = 0; done_cnt[i] = 0;
    end
  endtask

  task automatic send_all(logic [7:0] d, logic force_tick);
    tx_data = d;
    tx_valid = 1'b1;
    tick_force = force_tick;
    cyc();
    tx_valid = 1'b0;
    tick_force = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    bit all2;
    rst_n = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) idle_code[i] = st_w[i];
    check_vec("reset_tx", 32'(tx_w), 32'h1F);
    check_vec("reset_ready", 32'(ready_w), 32'h1F);
    check_vec("reset_done", 32'(done_w), 32'h0);
    rst_n = 1'b1;
    cyc(); cyc();

    // T1: 8N1, tick every 4 clk, 0x55
    clr_cap();
    send_all(8'h55, 1'b0);
    wait_all_idle(400);
    check_vec("t1_frame", cap[0], 32'h2AA);
    check_vec("t1_len", 32'(cap_n[0]), 32'd10);
    check_vec("t1_done_once", 32'(done_cnt[0]), 32'd1);

    // T2: parity even/odd on 0x07, plus 5-bit odd parity two stops
    clr_cap();
    send_all(8'h07, 1'b0);
    wait_all_idle(400);
    check_vec("t2_even_frame", cap[1], 32'h60E);
    check_vec("t2_even_len", 32'(cap_n[1]), 32'd11);
    check_vec("t2_odd_frame", cap[2], 32'h40E);
    check_vec("t2_dw5_frame", cap[4], 32'h18E);
    check_vec("t2_dw5_len", 32'(cap_n[4]), 32'd9);

    // T3: two stop bits, tick every clk, 0xA3
    tick_mode = 2;
    clr_cap();
    send_all(8'hA3, 1'b0);
    wait_all_idle(100);
    check_vec("t3_frame", cap[3], 32'h746);
    check_vec("t3_len", 32'(cap_n[3]), 32'd11);

    // T4: held valid, 0x12 then 0x34 back to back
    tick_mode = 1;
    tick_per = 4;
    clr_cap();
    tx_data = 8'h12;
    tx_valid = 1'b1;
    c = 0;
    all2 = 1'b0;
    while (!all2 && c < 400) begin
      cyc();
      c++;
      if (acc_cnt[0] >= 1) tx_data = 8'h34;
      all2 = 1'b1;
      for (int i = 0; i < N; i++) if (acc_cnt[i] < 2) all2 = 1'b0;
    end
    tx_valid = 1'b0;
    if (!all2) begin
      n_checks++;
      n_fail++;
      $display("FAIL t4_accept: second word not taken within 400 cycles");
    end
    wait_all_idle(400);
    check_vec("t4_frames", cap[0], 32'h0009A224);
    check_vec("t4_len", 32'(cap_n[0]), 32'd20);
    check_vec("t4_done_cnt", 32'(done_cnt[0]), 32'd2);

    // T5: tick in accept cycle is not used; valid while busy is ignored
    tick_mode = 0;
    clr_cap();
    send_all(8'h3C, 1'b1);
    repeat (3) cyc();
    check_vec("t5_armed_tx", 32'(tx_w), 32'h1F);
    check_vec("t5_armed_ready", 32'(ready_w), 32'h0);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    tx_data = 8'h00;
    tick_cnt = 0;
    tick_mode = 1;
    wait_all_idle(400);
    check_vec("t5_frame", cap[0], 32'h278);
    check_vec("t5_len", 32'(cap_n[0]), 32'd10);

    // T6: reset during data bit 3, then a clean 0xF0 frame
    clr_cap();
    send_all(8'hF0, 1'b0);
    c = 0;
    while (m_pos[0] != 5 && c < 200) begin
      cyc();
      c++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_vec("t6_async_tx", 32'(tx_w), 32'h1F);
    check_vec("t6_async_ready", 32'(ready_w), 32'h1F);
    check_vec("t6_async_done", 32'(done_w), 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    check_vec("t6_no_done", 32'(done_cnt[0]), 32'd0);
    clr_cap();
    send_all(8'hF0, 1'b0);
    wait_all_idle(400);
    check_vec("t6_frame", cap[0], 32'h3E0);

    // random traffic
    tick_mode = 3;
    repeat (3000) begin
      cyc();
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        tick_mode = $urandom_range(1, 3);
        tick_per = $urandom_range(1, 5);
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end
    end
    tx_valid = 1'b0;
    tick_mode = 2;
    wait_all_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
